// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: multiply/divide FSM states, op codes
// and the default HI/LO width.
package mips_pkg;

    localparam int unsigned MD_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } muldiv_state_t;

    // funct[1:0] of MULT/MULTU/DIV/DIVU
    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

endpackage

// File: rtl/muldiv_core.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step
// on a shared 2*WIDTH accumulator.
module muldiv_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   acc_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Mult: acc = {partial product, multiplier}; operand = multiplicand.
    // Div:  acc = {remainder, dividend/quotient}; operand = divisor.
    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? operand : {WIDTH{1'b0}})};
        shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff     = shifted - {1'b0, operand};
        acc_next = {sum, acc[WIDTH-1:1]};
        if (is_div) begin
            if (!diff[WIDTH]) begin
                acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, with MTHI/MTLO writes,
// MFHI/MFLO reads and a stall toward the datapath while busy.
module muldiv_unit import mips_pkg::*; #(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             spregwrite,
    input  logic             resmove,
    input  logic             spaddr,
    input  logic             mf,
    input  logic [1:0]       funct,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic [WIDTH-1:0] rdata,
    output logic             busy,
    output logic             stall
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    muldiv_state_t      state, next_state;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc, acc_next;
    logic [WIDTH-1:0]   operand;
    logic               is_div, neg_q, neg_r, div_zero;
    logic [WIDTH-1:0]   hi, lo;

    logic               start, mt_write, signed_op;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;

    assign start     = (state == IDLE) && spregwrite && resmove;
    assign mt_write  = (state == IDLE) && spregwrite && !resmove;
    assign signed_op = !funct[0];
    assign mag_a     = (signed_op && srca[WIDTH-1]) ? (~srca + 1'b1) : srca;
    assign mag_b     = (signed_op && srcb[WIDTH-1]) ? (~srcb + 1'b1) : srcb;

    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .is_div   (is_div),
        .acc      (acc),
        .operand  (operand),
        .acc_next (acc_next)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (count == CW'(WIDTH - 1)) next_state = FIX;
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state != IDLE);
        end
    end

    // Divide-by-zero forces LO to all-ones; HI already comes back as srca
    // because the remainder magnitude equals |srca| and carries srca's sign.
    always_comb begin
        prod = neg_q ? (~acc + 1'b1) : acc;
        quo  = div_zero ? '1 : (neg_q ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0]);
        rem  = neg_r ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            acc      <= '0;
            operand  <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        count    <= '0;
                        is_div   <= funct[1];
                        neg_q    <= signed_op && (srca[WIDTH-1] ^ srcb[WIDTH-1]);
                        neg_r    <= signed_op && srca[WIDTH-1];
                        div_zero <= funct[1] && (srcb == '0);
                        if (funct[1]) begin
                            acc     <= {{WIDTH{1'b0}}, mag_a};
                            operand <= mag_b;
                        end else begin
                            acc     <= {{WIDTH{1'b0}}, mag_b};
                            operand <= mag_a;
                        end
                    end else if (mt_write) begin
                        if (spaddr) lo <= srca;
                        else        hi <= srca;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    count <= count + 1'b1;
                end
                FIX: begin
                    if (is_div) begin
                        lo <= quo;
                        hi <= rem;
                    end else begin
                        lo <= prod[WIDTH-1:0];
                        hi <= prod[2*WIDTH-1:WIDTH];
                    end
                end
                default: ;
            endcase
        end
    end

    assign rdata = spaddr ? lo : hi;
    assign stall = (mf || spregwrite) && busy;

endmodule
